// File: rtl/mcp3008_responder.sv
// Behavioural MCP3008 SPI responder: decodes start/SGL/D2..D0 and returns ch_data[ch] on DOUT.
// Optional LSB-first tail after B0 is enabled by defining MCP3008_LSB_TAIL_EN.
module mcp3008_responder #(
    parameter int N           = 10,
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS-1:0][N-1:0]   ch_data,
    input  logic                         CS_n,
    input  logic                         SCLK,
    input  logic                         SPI_IN,
    output logic                         SPI_OUT,
    output logic                         dout_oe,
    output logic                         cmd_sgl,
    output logic [2:0]                   cmd_ch,
    output logic                         conv_strobe,
    output logic                         busy
);

    localparam int CNT_W = $clog2(N);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        MSB_OUT,
        LSB_OUT,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic [SYNC_STAGES-1:0] flush_sr;
    logic                   sclk_prev_p0;
    logic                   armed;
    logic [CNT_W-1:0]       bit_cnt;
    logic [2:0]             cmd_sr;
    logic [N-1:0]           word_q;

    logic cs_s;
    logic sclk_s;
    logic din_s;
    logic sclk_rise;
    logic sclk_fall;

    function automatic logic [N-1:0] sel_word(input logic [CHANNELS-1:0][N-1:0] d,
                                              input logic [2:0] ch);
        logic [N-1:0] result;
        result = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == 3'(i)) result = d[i];
        end
        return result;
    endfunction

    // Synchronizer stage: pins into the clk domain, edge detect on the last two SCLK samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync      <= '1;
            sclk_sync    <= '0;
            din_sync     <= '0;
            flush_sr     <= '0;
            sclk_prev_p0 <= 1'b0;
            armed        <= 1'b0;
        end else begin
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], CS_n};
            sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            din_sync     <= {din_sync[SYNC_STAGES-2:0], SPI_IN};
            flush_sr     <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_p0 <= sclk_s;
            // A transfer may only begin once a genuine CS_n high has been seen after reset
            armed        <= armed | (flush_sr[SYNC_STAGES-1] & cs_s);
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_p0;
    assign sclk_fall = ~sclk_s & sclk_prev_p0;

    // Data stage: command shift and result capture
    always_ff @(posedge clk) begin
        if (state == CMD && sclk_rise && !cs_s)
            cmd_sr <= {cmd_sr[1:0], din_s};
        if (state == SAMPLE && sclk_fall && !cs_s)
            word_q <= sel_word(ch_data, cmd_ch);
    end

    // Control stage: transfer sequencing and registered pin outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            SPI_OUT     <= 1'b0;
            dout_oe     <= 1'b0;
            cmd_sgl     <= 1'b0;
            cmd_ch      <= 3'd0;
            conv_strobe <= 1'b0;
            busy        <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            conv_strobe <= 1'b0;
            if (state != IDLE && cs_s) begin
                state   <= IDLE;
                SPI_OUT <= 1'b0;
                dout_oe <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        SPI_OUT <= 1'b0;
                        dout_oe <= 1'b0;
                        busy    <= 1'b0;
                        if (armed && !cs_s) state <= WAIT_START;
                    end
                    WAIT_START: begin
                        if (sclk_rise && din_s) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(3)) begin
                                cmd_sgl <= cmd_sr[2];
                                cmd_ch  <= {cmd_sr[1:0], din_s};
                                state   <= SAMPLE;
                            end
                        end
                    end
                    SAMPLE: begin
                        if (sclk_fall) begin
                            conv_strobe <= 1'b1;
                            SPI_OUT     <= 1'b0;
                            dout_oe     <= 1'b1;
                            bit_cnt     <= '0;
                            state       <= MSB_OUT;
                        end
                    end
                    MSB_OUT: begin
                        if (sclk_fall) begin
                            SPI_OUT <= word_q[CNT_W'(N-1) - bit_cnt];
                            if (bit_cnt == CNT_W'(N-1)) begin
                                bit_cnt <= '0;
`ifdef MCP3008_LSB_TAIL_EN
                                state   <= LSB_OUT;
`else
                                state   <= DONE;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
`ifdef MCP3008_LSB_TAIL_EN
                    LSB_OUT: begin
                        // B0 is shared with the MSB-first word, so the tail starts at B1
                        if (sclk_fall) begin
                            SPI_OUT <= word_q[bit_cnt + CNT_W'(1)];
                            if (bit_cnt == CNT_W'(N-2)) state <= DONE;
                            else bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
`endif
                    DONE: begin
                        dout_oe <= 1'b1;
                        if (sclk_fall) SPI_OUT <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        SPI_OUT <= 1'b0;
                        dout_oe <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mcp3008_responder.md
# mcp3008_responder

Synchronous behavioural emulation of the MCP3008 10-bit SPI ADC, acting as the SPI responder for our `mcp3008_audio` initiator. It takes the initiator's CS_n/SCLK/DIN, decodes the start bit and channel command, and returns a 10-bit word on DOUT taken from a parallel per-channel input. It is used for on-board loopback tests and as the ADC model in the audio-chain benches, so the filter path can run without the physical converter.

## Interface
- `N`, 10: result width in bits.
- `CHANNELS`, 8: number of emulated input channels; max 8.
- `SYNC_STAGES`, 2: synchronizer depth on CS_n, SCLK and DIN; minimum 2.

- `clk`  in  1  system clock; must be ≥ 8× SCLK frequency.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ch_data`  in  CHANNELS×N  value returned for each channel, packed `[CHANNELS-1:0][N-1:0]`.
- `CS_n`  in  1  chip select from the initiator, active low.
- `SCLK`  in  1  SPI clock from the initiator.
- `SPI_IN`  in  1  DIN from the initiator.
- `SPI_OUT`  out  1  DOUT to the initiator.
- `dout_oe`  out  1  high while DOUT is actively driven; low means high-Z at the top level.
- `cmd_sgl`  out  1  latched SGL/DIFF bit of the last command.
- `cmd_ch`  out  3  latched D2..D0 of the last command.
- `conv_strobe`  out  1  one-clk pulse when `ch_data` is latched.
- `busy`  out  1  high from the start bit until CS_n deasserts.

## Operation
- CS_n, SCLK and SPI_IN pass through SYNC_STAGES flops. SCLK rise and fall are detected by comparing the last two synchronized values.
- States:
  - IDLE: CS_n high. SPI_OUT=0, dout_oe=0. Go to WAIT_START when CS_n goes low.
  - WAIT_START: on each SCLK rise, if DIN=1, go to CMD with bit counter=0. Leading zeros are ignored.
  - CMD: on SCLK rises 1..4 after the start bit, shift in SGL, D2, D1, D0. After the 4th rise, latch `cmd_sgl`/`cmd_ch` and go to SAMPLE.
  - SAMPLE: on the next SCLK fall (fall #5 after the start), latch `ch_data[cmd_ch]` into the shift register and pulse `conv_strobe`. Drive the null bit: SPI_OUT=0, dout_oe=1. Go to MSB_OUT.
  - MSB_OUT: on falls #6..#15, drive B9..B0.
  - LSB_OUT (macro-dependent, see Configuration): on falls #16..#24, drive B1..B9.
  - DONE: SPI_OUT=0, dout_oe=1 until CS_n goes high.
- A CS_n rise in any state goes to IDLE in the same clk it is detected, with SPI_OUT=0 and dout_oe=0. A partial transfer is discarded; `cmd_*` keep their last completed values.
- If `cmd_ch` ≥ CHANNELS, the result is 0.
- Differential mode (SGL=0) returns the same `ch_data[cmd_ch]` value. No difference is computed; only `cmd_sgl` reflects the mode.
- `busy` is high from the CMD entry through DONE.
- `ch_data` is sampled only at `conv_strobe`. Later changes do not affect the word in flight.

## Timing
- Reset values: SPI_OUT=0, dout_oe=0, cmd_sgl=0, cmd_ch=0, conv_strobe=0, busy=0. State is IDLE and synchronizers are cleared to CS_n=1, SCLK=0, DIN=0. An assertion mid-transfer takes effect immediately; after release, the block waits for a fresh CS_n fall.
- DOUT latency: SPI_OUT changes SYNC_STAGES+1 clk after the pin-level SCLK fall (3 clk at default). This is 60 ns at 50 MHz, well inside half an SCLK period at 1.5625 MHz.
- `conv_strobe` and the null bit assert in the same clk.
- A CS_n rise and an SCLK edge detected in the same clk: the CS_n rise wins.
- SCLK idles low (SPI mode 0,0). Mode 1,1 is not supported.

## Configuration
- `MCP3008_LSB_TAIL_EN` defined: after B0, falls #16..#24 drive B1..B9 (LSB-first tail, B0 shared), then DONE.
- Undefined: MSB_OUT goes directly to DONE after B0, and SPI_OUT stays 0.

## Test plan
- Reset, then CS_n low with 26 SCLK cycles, DIN = 1,1,0,1,1 then 0s, `ch_data[3]`=10'h2A5 → null bit 0, then 1010100101 MSB-first; cmd_sgl=1, cmd_ch=3, one `conv_strobe`.
- Same stimulus with `MCP3008_LSB_TAIL_EN` → after B0, 010010101 (B1..B9) on falls #16..#24, then 0.
- Three leading zeros before the start bit, channel 7, `ch_data[7]`=10'h3FF → ten 1s after the null bit; `busy` rises only after the start bit.
- CS_n raised after fall #9 → SPI_OUT=0 and dout_oe=0 within SYNC_STAGES+1 clk. The next full transfer on channel 0 (10'h001) returns correct data.
- `ch_data[2]` changes from 10'h100 to 10'h0FF one clk after `conv_strobe` → 0100000000 still returned.
- reset_n pulsed low during MSB_OUT → all outputs 0 immediately; no DOUT activity until the next CS_n fall.
